// File: rtl/push_conditioner_pkg.sv
// Shared constants and types for the push-button conditioning path.
// Cycle counts assume a 100 MHz system clock.
package push_conditioner_pkg;

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_M = 4;

  localparam int N_BTN_DEF           = 5;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int HOLD_CYCLES_DEF     = 50000000;
  localparam int REPEAT_CYCLES_DEF   = 10000000;
  localparam logic [4:0] REPEAT_MASK_DEF = (5'b00001 << BTN_U) | (5'b00001 << BTN_D);

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic rpt;
  } btn_evt_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/push_channel.sv
// One button: 2-FF synchroniser, debounce filter, press/release pulses and
// optional auto-repeat pulse train while the debounced level is held high.
module push_channel
  import push_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int HR_W = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HR_W-1:0] HOLD_LAST = HR_W'(HOLD_CYCLES - 1);
  localparam logic [HR_W-1:0] RPT_LAST  = HR_W'(REPEAT_CYCLES - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic [DB_W-1:0] db_cnt_r;
  logic [HR_W-1:0] hold_cnt_r;
  logic            rpt_phase_r;

  logic            differ_s;
  logic            toggle_s;
  logic            level_next_s;
  logic [HR_W-1:0] hold_term_s;
  logic            fire_s;

  assign differ_s     = sync2_r ^ btn_level;
  assign toggle_s     = differ_s && (db_cnt_r == DB_LAST);
  assign level_next_s = btn_level ^ toggle_s;
  // Hold window until the first repeat, then the shorter repeat period.
  assign hold_term_s  = rpt_phase_r ? RPT_LAST : HOLD_LAST;
  assign fire_s       = REPEAT_EN && btn_level && !toggle_s && (hold_cnt_r == hold_term_s);

  // Synchroniser, debounce counter and registered level/edge outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      db_cnt_r    <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync1_r     <= push;
      sync2_r     <= sync1_r;
      if (toggle_s || !differ_s) begin
        db_cnt_r <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
      btn_level   <= level_next_s;
      btn_press   <= toggle_s && !btn_level;
      btn_release <= toggle_s && btn_level;
    end
  end

  // Hold/repeat counter; restarts on press, clears on release, reloads on each pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r  <= '0;
      rpt_phase_r <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      btn_repeat <= fire_s;
      if (!REPEAT_EN || !level_next_s || toggle_s) begin
        hold_cnt_r  <= '0;
        rpt_phase_r <= 1'b0;
      end else if (fire_s) begin
        hold_cnt_r  <= '0;
        rpt_phase_r <= 1'b1;
      end else if (hold_cnt_r != hold_term_s) begin
        hold_cnt_r  <= hold_cnt_r + HR_W'(1);
        rpt_phase_r <= rpt_phase_r;
      end else begin
        hold_cnt_r  <= hold_cnt_r;
        rpt_phase_r <= rpt_phase_r;
      end
    end
  end

endmodule

// File: rtl/push_conditioner.sv
// Conditions the raw push buttons into debounced levels and single-cycle
// press/release/repeat events; one independent channel per button.
module push_conditioner
  import push_conditioner_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(REPEAT_MASK_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] push,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);

  btn_evt_t evt_s [N_BTN];

  genvar g;
  generate
    for (g = 0; g < N_BTN; g++) begin : g_chan
      push_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (REPEAT_MASK[g])
      ) u_chan (
        .clk         (clk),
        .reset       (reset),
        .push        (push[g]),
        .btn_level   (evt_s[g].level),
        .btn_press   (evt_s[g].press),
        .btn_release (evt_s[g].rel),
        .btn_repeat  (evt_s[g].rpt)
      );
      assign btn_level[g]   = evt_s[g].level;
      assign btn_press[g]   = evt_s[g].press;
      assign btn_release[g] = evt_s[g].rel;
      assign btn_repeat[g]  = evt_s[g].rpt;
    end
  endgenerate

  // OR of registered press flops, so it shares their timing.
  assign any_press = |btn_press;

endmodule

// File: tb/tb_push_conditioner.sv
// Self-checking bench: timestamp-based reference model compared every cycle,
// a vector table, hand-written corner sequences and randomized button activity.
module tb_push_conditioner;

  localparam int NB = 5;
  localparam int DB = 4;
  localparam int HD = 10;
  localparam int RP = 3;
  localparam logic [4:0] MASK = 5'b00011;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] push;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic          any_press;

  push_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HD), .REPEAT_CYCLES(RP), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .push(push),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .any_press(any_press)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  int cyc   = 0;

  // Reference model: raw history, run length of disagreement, level and press timestamp.
  logic [4:0] m_d0, m_d1, m_lvl, m_prs, m_rel, m_rpt;
  int m_run [NB];
  int m_tp  [NB];

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d cyc=%0d got=%b want=%b", name, t, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [4:0] p);
    logic [4:0] s;
    int k;
    if (rst) begin
      m_d0 = '0; m_d1 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_rpt = '0;
      for (int i = 0; i < NB; i++) begin m_run[i] = 0; m_tp[i] = 0; end
    end else begin
      s = m_d1; m_d1 = m_d0; m_d0 = p;
      m_prs = '0; m_rel = '0; m_rpt = '0;
      for (int i = 0; i < NB; i++) begin
        if (s[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_run[i] = 0;
            m_lvl[i] = ~m_lvl[i];
            if (m_lvl[i]) begin m_prs[i] = 1'b1; m_tp[i] = t; end
            else m_rel[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
        if (MASK[i] && m_lvl[i] && !m_prs[i]) begin
          k = t - m_tp[i];
          if (k >= HD && ((k - HD) % RP) == 0) m_rpt[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    cyc++;
    model_edge(reset, push);
    #1;
    chk("model_level",   btn_level,   m_lvl);
    chk("model_press",   btn_press,   m_prs);
    chk("model_release", btn_release, m_rel);
    chk("model_repeat",  btn_repeat,  m_rpt);
    chk("model_any",     {4'b0000, any_press}, {4'b0000, |m_prs});
  endtask

  task automatic start_phase();
    reset = 1'b1;
    push  = '0;
    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  typedef struct {
    logic [4:0] push;
    logic [4:0] lvl, prs, rel, rpt;
    logic       any;
  } vec_t;

  vec_t tbl [20];
  int rep_q [$];
  int prs_q [$];
  int rel_at, rpt_cnt, nz;
  int rem [NB];

  initial begin
    reset = 1'b1;
    push  = '0;

    // Rows 0..9: 3-cycle glitch on push[0]; rows 10..19: push[0] and push[3] rise together.
    for (int i = 0; i < 20; i++) begin
      tbl[i].push = (i < 3) ? 5'b00001 : ((i >= 10) ? 5'b01001 : 5'b00000);
      tbl[i].lvl  = (i >= 16) ? 5'b01001 : 5'b00000;
      tbl[i].prs  = (i == 16) ? 5'b01001 : 5'b00000;
      tbl[i].rel  = 5'b00000;
      tbl[i].rpt  = 5'b00000;
      tbl[i].any  = (i == 16);
    end

    start_phase();
    for (int i = 0; i < 20; i++) begin
      push = tbl[i].push;
      chk("tbl_level",   btn_level,   tbl[i].lvl);
      chk("tbl_press",   btn_press,   tbl[i].prs);
      chk("tbl_release", btn_release, tbl[i].rel);
      chk("tbl_repeat",  btn_repeat,  tbl[i].rpt);
      chk("tbl_any",     {4'b0000, any_press}, {4'b0000, tbl[i].any});
      tick();
    end

    // Hold push[0] for cycles 0..29 and watch repeats and the release.
    start_phase();
    rep_q.delete(); prs_q.delete(); rel_at = -1;
    for (int c = 0; c <= 45; c++) begin
      push = (c < 30) ? 5'b00001 : 5'b00000;
      if (btn_repeat[0])  rep_q.push_back(c);
      if (btn_press[0])   prs_q.push_back(c);
      if (btn_release[0]) rel_at = c;
      tick();
    end
    chk_int("hold_press_count", prs_q.size(), 1);
    chk_int("hold_press_cycle", (prs_q.size() > 0) ? prs_q[0] : -1, 6);
    chk_int("hold_release_cycle", rel_at, 36);
    begin
      int n = 0;
      for (int j = 0; j < rep_q.size(); j++) begin
        if (rep_q[j] <= 30) begin
          chk_int("hold_repeat_cycle", rep_q[j], 16 + 3 * n);
          n++;
        end
        if (rep_q[j] >= 36) chk_int("repeat_after_release", rep_q[j], -1);
      end
      chk_int("hold_repeat_count", n, 5);
    end

    // Unmasked middle button held 40 cycles.
    start_phase();
    prs_q.delete(); rel_at = -1; rpt_cnt = 0;
    for (int c = 0; c <= 55; c++) begin
      push = (c < 40) ? 5'b10000 : 5'b00000;
      if (btn_press[4])   prs_q.push_back(c);
      if (btn_release[4]) rel_at = c;
      if (btn_repeat[4])  rpt_cnt++;
      tick();
    end
    chk_int("mid_press_count", prs_q.size(), 1);
    chk_int("mid_press_cycle", (prs_q.size() > 0) ? prs_q[0] : -1, 6);
    chk_int("mid_repeat_count", rpt_cnt, 0);
    chk_int("mid_release_cycle", rel_at, 46);

    // push[1] held through a 2-cycle reset at cycles 12..13.
    start_phase();
    prs_q.delete(); rep_q.delete(); nz = 0;
    for (int c = 0; c <= 40; c++) begin
      push  = 5'b00010;
      reset = (c == 12 || c == 13);
      if (c >= 13 && c <= 19 && (btn_level | btn_press | btn_release | btn_repeat) != 5'b00000) nz++;
      if (btn_press[1])  prs_q.push_back(c);
      if (btn_repeat[1]) rep_q.push_back(c);
      tick();
    end
    reset = 1'b0;
    chk_int("rst_outputs_nonzero", nz, 0);
    chk_int("rst_press_count", prs_q.size(), 2);
    chk_int("rst_press_refire", (prs_q.size() > 1) ? prs_q[1] : -1, 20);
    chk_int("rst_first_repeat", (rep_q.size() > 0) ? rep_q[0] : -1, 30);

    // Randomized button activity with occasional resets.
    start_phase();
    for (int i = 0; i < NB; i++) rem[i] = $urandom_range(1, 20);
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NB; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          push[i] = ~push[i];
          rem[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 40));
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
